button_event_gen: RTL and testbench

- Sits directly downstream of the per-button debouncer in the SPI up-counter design.
- Converts one debounced button level into single-cycle event pulses: press, release, short press, long press, and auto-repeat while held.
- These pulses drive the counter control logic and the SPI command sequencer.
- Fully synchronous, with one internal millisecond prescaler.

---
 rtl/button_event_gen.sv | 133 +++++++++++++
 tb/tb_button_event_gen.sv | 111 +++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press/release/short/long/repeat pulses plus a held level.
// Every output is registered: a pulse is high for the one cycle after the edge that samples its condition.
module button_event_gen #(
    parameter int TICK_DIV  = 100_000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter bit REPEAT_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(LONG_MS + 1);
    localparam int RW = $clog2(REPEAT_MS + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic [RW-1:0] rep_q,   rep_d;
    logic          btn_q;

    logic press_d, release_d, short_d, long_d, repeat_d, held_d;
    logic press_edge, release_edge, tick;

    assign press_edge   = i_btn & ~btn_q;
    assign release_edge = ~i_btn & btn_q;
    assign tick         = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (press_edge) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                end
            end
            PRESSED: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                // Release is checked first so it beats a long threshold in the same cycle.
                if (release_edge) begin
                    state_d   = IDLE;
                    presc_d   = '0;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                end else if (tick) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HW'(LONG_MS - 1)) begin
                        state_d = LONG_HOLD;
                        long_d  = 1'b1;
                        rep_d   = '0;
                    end
                end
            end
            LONG_HOLD: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (release_edge) begin
                    state_d   = IDLE;
                    presc_d   = '0;
                    release_d = 1'b1;
                end else if (tick) begin
                    if (rep_q == RW'(REPEAT_MS - 1)) begin
                        repeat_d = REPEAT_EN;
                        rep_d    = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    // btn_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            btn_q     <= 1'b1;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_short   <= 1'b0;
            o_long    <= 1'b0;
            o_repeat  <= 1'b0;
            o_held    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            btn_q     <= i_btn;
            o_press   <= press_d;
            o_release <= release_d;
            o_short   <= short_d;
            o_long    <= long_d;
            o_repeat  <= repeat_d;
            o_held    <= held_d;
        end
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench: two instances (repeat enabled / disabled) driven by the same button, checked per cycle.
module tb_button_event_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_btn = 1'b1;

    logic a_press, a_release, a_short, a_long, a_repeat, a_held;
    logic b_press, b_release, b_short, b_long, b_repeat, b_held;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_event_gen #(.TICK_DIV(10), .LONG_MS(5), .REPEAT_MS(3), .REPEAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .i_btn(i_btn),
        .o_press(a_press), .o_release(a_release), .o_short(a_short),
        .o_long(a_long), .o_repeat(a_repeat), .o_held(a_held)
    );

    button_event_gen #(.TICK_DIV(10), .LONG_MS(5), .REPEAT_MS(3), .REPEAT_EN(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .i_btn(i_btn),
        .o_press(b_press), .o_release(b_release), .o_short(b_short),
        .o_long(b_long), .o_repeat(b_repeat), .o_held(b_held)
    );

    // Vector order: {press, release, short, long, repeat, held}
    wire [5:0] obs_a = {a_press, a_release, a_short, a_long, a_repeat, a_held};
    wire [5:0] obs_b = {b_press, b_release, b_short, b_long, b_repeat, b_held};

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Press sampled at edge 0; release sampled at edge rel. Cycle c is observed after edge c-1.
    task automatic run_scn(input string name, input int rel, input int long_c,
                           input int reps[5], input bit short_e);
        logic [5:0] exp;
        logic       rp;
        @(negedge clk);
        i_btn = 1'b1;
        for (int c = 1; c <= rel + 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == rel) i_btn = 1'b0;
            rp = 1'b0;
            for (int k = 0; k < 5; k++) if (reps[k] == c) rp = 1'b1;
            exp = {c == 1, c == rel + 1, short_e && (c == rel + 1), c == long_c, rp,
                   (c >= 1) && (c <= rel)};
            chk($sformatf("%s_en_c%0d", name, c), obs_a, exp);
            exp[1] = 1'b0;
            chk($sformatf("%s_nr_c%0d", name, c), obs_b, exp);
        end
    endtask

    initial begin
        // Button held through reset.
        #12;
        chk("rst_a", obs_a, 6'b0);
        chk("rst_b", obs_b, 6'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("held_thru_rst_c%0d", c), obs_a, 6'b0);
        end
        @(negedge clk);
        i_btn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("after_rst_low_c%0d", c), obs_a, 6'b0);
        end

        run_scn("short20",  20,  -1, '{-1, -1, -1, -1, -1}, 1'b1);
        run_scn("long120",  120, 51, '{81, 111, -1, -1, -1}, 1'b0);
        run_scn("edge50",   50,  -1, '{-1, -1, -1, -1, -1}, 1'b1);
        run_scn("hold200",  200, 51, '{81, 111, 141, 171, -1}, 1'b0);
        run_scn("relrep140", 140, 51, '{81, 111, -1, -1, -1}, 1'b0);

        // Reset asserted mid long hold.
        @(negedge clk);
        i_btn = 1'b1;
        repeat (59) @(posedge clk);
        @(negedge clk);
        chk("midhold_c59", obs_a, 6'b000001);
        rst = 1'b0;
        #1;
        chk("midhold_rst_a", obs_a, 6'b0);
        chk("midhold_rst_b", obs_b, 6'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_held_c%0d", c), obs_a, 6'b0);
        end
        i_btn = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_rel_c%0d", c), obs_a, 6'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
